// File: rtl/acc_biu_pkg.sv
// Shared definitions for the accelerator bus interface units (weight / imap BIUs).
package acc_biu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } biu_state_e;

  // Bits needed to index n entries; never less than 1.
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/weight_biu_if.sv
// Weight BIU <-> ICB arbiter channels: read command out, read response back.
interface weight_biu_if;

  logic        weight_biu2arb_req;
  logic [31:0] weight_biu2arb_addr;
  logic        weight_biu2arb_vld;
  logic        weight_biu2arb_rdy;
  logic [31:0] arb2weight_biu_addr;
  logic [31:0] arb2weight_biu_data;
  logic        arb2weight_biu_vld;
  logic        arb2weight_biu_rdy;

  modport master (
    output weight_biu2arb_req,
    output weight_biu2arb_addr,
    output weight_biu2arb_vld,
    input  weight_biu2arb_rdy,
    input  arb2weight_biu_addr,
    input  arb2weight_biu_data,
    input  arb2weight_biu_vld,
    output arb2weight_biu_rdy
  );

  modport slave (
    input  weight_biu2arb_req,
    input  weight_biu2arb_addr,
    input  weight_biu2arb_vld,
    output weight_biu2arb_rdy,
    output arb2weight_biu_addr,
    output arb2weight_biu_data,
    output arb2weight_biu_vld,
    input  arb2weight_biu_rdy
  );

endinterface

// File: rtl/biu_rsp_fifo.sv
// Single-clock response FIFO; registered head, no write-through bypass.
module biu_rsp_fifo
  import acc_biu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = clog2_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A pop frees a slot in the same cycle, so push on full succeeds alongside it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/weight_biu.sv
// Weight fetch BIU: issues credit-limited incrementing reads and streams the words out.
module weight_biu
  import acc_biu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] word_len,
  output logic             busy,
  output logic             done,
  output logic             addr_err,
  weight_biu_if.master     bus,
  output logic [31:0]      wt_data,
  output logic             wt_vld,
  input  logic             wt_rdy,
  output logic             wt_last
);

  localparam int unsigned CNT_W = clog2_w(FIFO_DEPTH) + 1;

  biu_state_e       r_state;
  biu_state_e       w_state_nxt;
  logic [31:0]      r_base;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issue_cnt;
  logic [LEN_W-1:0] r_rsp_cnt;
  logic [LEN_W-1:0] r_pop_cnt;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_addr_err;

  logic             w_start_ok;
  logic             w_credit_ok;
  logic             w_cmd_fire;
  logic             w_rsp_fire;
  logic             w_pop;
  logic             w_final_cmd;
  logic             w_last_word;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [31:0]      w_fifo_rdata;
  logic [31:0]      w_exp_addr;

  assign w_start_ok  = start && (r_state == StIdle);
  // In-flight reads plus buffered words never exceed the FIFO, so responses are never refused.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign w_cmd_fire  = bus.weight_biu2arb_vld && bus.weight_biu2arb_rdy;
  assign w_rsp_fire  = bus.arb2weight_biu_vld && bus.arb2weight_biu_rdy;
  assign w_pop       = wt_vld && wt_rdy;
  assign w_final_cmd = (r_issue_cnt == (r_len - LEN_W'(1)));
  assign w_last_word = (r_pop_cnt == (r_len - LEN_W'(1)));
  assign w_exp_addr  = r_base + 32'(r_rsp_cnt) * WORD_BYTES;

  assign wt_vld   = !w_fifo_empty;
  assign wt_data  = wt_vld ? w_fifo_rdata : '0;
  assign wt_last  = wt_vld && w_last_word;
  assign addr_err = r_addr_err;

  always_comb begin
    w_state_nxt             = r_state;
    busy                    = 1'b0;
    done                    = 1'b0;
    bus.weight_biu2arb_req  = 1'b0;
    bus.weight_biu2arb_vld  = 1'b0;
    bus.weight_biu2arb_addr = r_base + 32'(r_issue_cnt) * WORD_BYTES;
    bus.arb2weight_biu_rdy  = (r_state != StIdle) && !w_fifo_full;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_nxt = (word_len != '0) ? StRun : StDone;
      end
      StRun: begin
        busy                   = 1'b1;
        bus.weight_biu2arb_req = 1'b1;
        bus.weight_biu2arb_vld = w_credit_ok;
        if (w_cmd_fire && w_final_cmd) w_state_nxt = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        if (w_pop && w_last_word) w_state_nxt = StDone;
      end
      StDone: begin
        done        = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_base        <= '0;
      r_len         <= '0;
      r_issue_cnt   <= '0;
      r_rsp_cnt     <= '0;
      r_pop_cnt     <= '0;
      r_outstanding <= '0;
      r_addr_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_base      <= base_addr & ~32'(WORD_BYTES - 1);
        r_len       <= word_len;
        r_issue_cnt <= '0;
        r_rsp_cnt   <= '0;
        r_pop_cnt   <= '0;
        r_addr_err  <= 1'b0;
      end else begin
        if (w_cmd_fire) r_issue_cnt <= r_issue_cnt + LEN_W'(1);
        if (w_rsp_fire) r_rsp_cnt <= r_rsp_cnt + LEN_W'(1);
        if (w_pop)      r_pop_cnt <= r_pop_cnt + LEN_W'(1);
        // Mismatched words are still buffered; a response while idle is dropped.
        if ((w_rsp_fire && (bus.arb2weight_biu_addr != w_exp_addr)) ||
            ((r_state == StIdle) && bus.arb2weight_biu_vld)) begin
          r_addr_err <= 1'b1;
        end
      end
      unique case ({w_cmd_fire, w_rsp_fire})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  biu_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_fire),
    .i_wdata (bus.arb2weight_biu_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_weight_biu.sv
// Directed bench for weight_biu with a small arbiter/memory model and a stream consumer.
module tb_weight_biu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_len;
  logic        busy, done, addr_err;
  logic [31:0] wt_data;
  logic        wt_vld, wt_rdy, wt_last;

  weight_biu_if u_if ();

  weight_biu #(
    .FIFO_DEPTH (8),
    .LEN_W      (16)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_len  (word_len),
    .busy      (busy),
    .done      (done),
    .addr_err  (addr_err),
    .bus       (u_if),
    .wt_data   (wt_data),
    .wt_vld    (wt_vld),
    .wt_rdy    (wt_rdy),
    .wt_last   (wt_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Model controls: arb_mode 0=rdy 1, 1=random, 2=rdy 0; wt_mode 0=rdy 1, 1=stall, 2=random.
  int          cyc = 0;
  int          arb_mode = 0;
  int          wt_mode = 0;
  int          dly = 2;
  int          jit = 0;
  int          corrupt_idx = -1;
  logic [31:0] corrupt_addr = '0;
  int          rsp_idx = 0;
  bit          inj_idle = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  int          stab_err = 0;
  int          rsp_stall = 0;
  logic [31:0] cmd_q[$];
  logic [31:0] pend_a[$];
  int          pend_due[$];
  logic [31:0] got_d[$];
  bit          got_l[$];

  // Arbiter + consumer model: decides inputs at negedge for the next rising edge.
  initial begin
    u_if.weight_biu2arb_rdy  = 1'b0;
    u_if.arb2weight_biu_vld  = 1'b0;
    u_if.arb2weight_biu_addr = '0;
    u_if.arb2weight_biu_data = '0;
    wt_rdy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_a.delete();
        pend_due.delete();
        prev_stall = 0;
        u_if.weight_biu2arb_rdy = 1'b0;
        u_if.arb2weight_biu_vld = 1'b0;
        wt_rdy = 1'b0;
      end else begin
        if (prev_stall && (!u_if.weight_biu2arb_vld || u_if.weight_biu2arb_addr !== prev_addr))
          stab_err++;
        case (arb_mode)
          0:       u_if.weight_biu2arb_rdy = 1'b1;
          1:       u_if.weight_biu2arb_rdy = 1'($urandom_range(0, 1));
          default: u_if.weight_biu2arb_rdy = 1'b0;
        endcase
        if (u_if.weight_biu2arb_vld && u_if.weight_biu2arb_rdy) begin
          cmd_q.push_back(u_if.weight_biu2arb_addr);
          pend_a.push_back(u_if.weight_biu2arb_addr);
          pend_due.push_back(cyc + dly + int'($urandom_range(0, jit)));
        end
        prev_stall = u_if.weight_biu2arb_vld && !u_if.weight_biu2arb_rdy;
        prev_addr  = u_if.weight_biu2arb_addr;
        if (inj_idle) begin
          u_if.arb2weight_biu_vld  = 1'b1;
          u_if.arb2weight_biu_addr = 32'hDEAD_0000;
          u_if.arb2weight_biu_data = 32'h0;
          inj_idle = 0;
        end else if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
          u_if.arb2weight_biu_vld  = 1'b1;
          u_if.arb2weight_biu_addr = (rsp_idx == corrupt_idx) ? corrupt_addr : pend_a[0];
          u_if.arb2weight_biu_data = ~pend_a[0];
          if (u_if.arb2weight_biu_rdy) begin
            void'(pend_a.pop_front());
            void'(pend_due.pop_front());
            rsp_idx++;
          end else begin
            rsp_stall++;
          end
        end else begin
          u_if.arb2weight_biu_vld = 1'b0;
        end
        case (wt_mode)
          0:       wt_rdy = 1'b1;
          1:       wt_rdy = 1'b0;
          default: wt_rdy = 1'($urandom_range(0, 1));
        endcase
        if (wt_vld && wt_rdy) begin
          got_d.push_back(wt_data);
          got_l.push_back(wt_last);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    cmd_q.delete();
    got_d.delete();
    got_l.delete();
    rsp_idx   = 0;
    stab_err  = 0;
    rsp_stall = 0;
  endtask

  task automatic issue(input logic [31:0] b, input logic [15:0] l);
    start     = 1'b1;
    base_addr = b;
    word_len  = l;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int c;
    c    = 0;
    seen = 0;
    while (!seen && c < budget) begin
      if (done) seen = 1;
      else begin
        step();
        c++;
      end
    end
  endtask

  task automatic test_reset();
    logic [39:0] obs;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_len = '0;
    step();
    step();
    obs = {busy, done, addr_err, u_if.weight_biu2arb_req, u_if.weight_biu2arb_vld,
           u_if.arb2weight_biu_rdy, wt_vld, wt_last, u_if.weight_biu2arb_addr};
    n_vec++;
    if (obs !== 40'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", obs, 40'h0);
    end
    n_vec++;
    if (wt_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_wt_data: got %h want %h", wt_data, 32'h0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    logic [3:0]  lp;
    bit          seen;
    exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    exp_d = '{32'hFFFF_EFFF, 32'hFFFF_EFFB, 32'hFFFF_EFF7, 32'hFFFF_EFF3};
    clear_sb();
    arb_mode = 0; wt_mode = 0; dly = 2; jit = 0;
    issue(32'h1000, 16'd4);
    n_vec++;
    if ({busy, u_if.weight_biu2arb_vld, u_if.weight_biu2arb_addr} !== {2'b11, 32'h1000}) begin
      n_err++;
      $display("FAIL basic_first_cmd: got busy=%b vld=%b addr=%h want 1 1 00001000",
               busy, u_if.weight_biu2arb_vld, u_if.weight_biu2arb_addr);
    end
    wait_done(200, seen);
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL basic_done: got no done want done pulse");
    end
    step();
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
    n_vec++;
    if (cmd_q.size() != 4 || got_d.size() != 4) begin
      n_err++;
      $display("FAIL basic_counts: got cmds=%0d words=%0d want 4 4", cmd_q.size(), got_d.size());
    end
    lp = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < cmd_q.size()) begin
        n_vec++;
        if (cmd_q[i] !== exp_a[i]) begin
          n_err++;
          $display("FAIL basic_addr[%0d]: got %h want %h", i, cmd_q[i], exp_a[i]);
        end
      end
      if (i < got_d.size()) begin
        lp[i] = got_l[i];
        n_vec++;
        if (got_d[i] !== exp_d[i]) begin
          n_err++;
          $display("FAIL basic_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]);
        end
      end
    end
    n_vec++;
    if (lp !== 4'b1000 || addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL basic_last_err: got last=%b err=%b want 1000 0", lp, addr_err);
    end
  endtask

  task automatic test_zero_len();
    int dc, bz, first;
    clear_sb();
    dc = 0; bz = 0; first = -1;
    issue(32'h1000, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      if (done) begin
        dc++;
        if (first < 0) first = k;
      end
      if (busy) bz++;
      step();
    end
    n_vec++;
    if (dc != 1 || bz != 0) begin
      n_err++;
      $display("FAIL zero_len_pulse: got done=%0d busy=%0d want 1 0", dc, bz);
    end
    n_vec++;
    if (first < 1 || first > 2) begin
      n_err++;
      $display("FAIL zero_len_latency: got %0d want 1..2", first);
    end
    n_vec++;
    if (cmd_q.size() != 0) begin
      n_err++;
      $display("FAIL zero_len_cmds: got %0d want 0", cmd_q.size());
    end
  endtask

  task automatic test_addr_err();
    logic [31:0] exp_d [4];
    bit          seen;
    exp_d = '{32'hFFFF_EFFF, 32'hFFFF_EFFB, 32'hFFFF_EFF7, 32'hFFFF_EFF3};
    clear_sb();
    corrupt_idx = 1;
    corrupt_addr = 32'h1008;
    issue(32'h1000, 16'd4);
    wait_done(200, seen);
    step(); step(); step();
    n_vec++;
    if (!seen || addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL addr_err_sticky: got done=%b err=%b want 1 1", seen, addr_err);
    end
    n_vec++;
    if (got_d.size() != 4) begin
      n_err++;
      $display("FAIL addr_err_count: got %0d want 4", got_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_d.size()) begin
        n_vec++;
        if (got_d[i] !== exp_d[i]) begin
          n_err++;
          $display("FAIL addr_err_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]);
        end
      end
    end
    corrupt_idx = -1;
    clear_sb();
    issue(32'h3003, 16'd2);
    n_vec++;
    if (addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL addr_err_clear: got %b want 0", addr_err);
    end
    wait_done(200, seen);
    step();
    n_vec++;
    if (!seen || cmd_q.size() != 2 || got_d.size() != 2) begin
      n_err++;
      $display("FAIL unaligned_counts: got done=%b cmds=%0d words=%0d want 1 2 2",
               seen, cmd_q.size(), got_d.size());
    end else begin
      n_vec++;
      if ({cmd_q[0], cmd_q[1], got_d[1]} !== {32'h3000, 32'h3004, 32'hFFFF_CFFB}) begin
        n_err++;
        $display("FAIL unaligned_addr: got %h %h %h want 00003000 00003004 ffffcffb",
                 cmd_q[0], cmd_q[1], got_d[1]);
      end
    end
    inj_idle = 1;
    step(); step(); step();
    n_vec++;
    if ({addr_err, wt_vld} !== 2'b10) begin
      n_err++;
      $display("FAIL idle_rsp: got err=%b wt_vld=%b want 1 0", addr_err, wt_vld);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int nl;
    clear_sb();
    arb_mode = 0; wt_mode = 1; dly = 2; jit = 0;
    issue(32'h8000, 16'd20);
    repeat (48) step();
    n_vec++;
    if (cmd_q.size() != 8 || u_if.weight_biu2arb_vld !== 1'b0) begin
      n_err++;
      $display("FAIL bp_credit: got cmds=%0d vld=%b want 8 0", cmd_q.size(),
               u_if.weight_biu2arb_vld);
    end
    wt_mode = 0;
    wait_done(400, seen);
    step();
    n_vec++;
    if (!seen || cmd_q.size() != 20 || got_d.size() != 20 || rsp_stall != 0) begin
      n_err++;
      $display("FAIL bp_counts: got done=%b cmds=%0d words=%0d stalls=%0d want 1 20 20 0",
               seen, cmd_q.size(), got_d.size(), rsp_stall);
    end
    nl = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_l[i]) nl++;
      n_vec++;
      if (got_d[i] !== ~(32'h8000 + 32'(i) * 4)) begin
        n_err++;
        $display("FAIL bp_data[%0d]: got %h want %h", i, got_d[i], ~(32'h8000 + 32'(i) * 4));
      end
    end
    n_vec++;
    if (nl != 1 || got_d.size() != 20 || !got_l[19]) begin
      n_err++;
      $display("FAIL bp_last: got %0d last flags want 1 on word 19", nl);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    bit          seen;
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    exp_d = '{32'h0000_0007, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    clear_sb();
    arb_mode = 1; wt_mode = 2; dly = 1; jit = 3;
    issue(32'hFFFF_FFF8, 16'd4);
    wait_done(400, seen);
    step();
    arb_mode = 0; wt_mode = 0; jit = 0;
    n_vec++;
    if (!seen || cmd_q.size() != 4 || got_d.size() != 4) begin
      n_err++;
      $display("FAIL wrap_counts: got done=%b cmds=%0d words=%0d want 1 4 4",
               seen, cmd_q.size(), got_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < cmd_q.size()) begin
        n_vec++;
        if (cmd_q[i] !== exp_a[i]) begin
          n_err++;
          $display("FAIL wrap_addr[%0d]: got %h want %h", i, cmd_q[i], exp_a[i]);
        end
      end
      if (i < got_d.size()) begin
        n_vec++;
        if (got_d[i] !== exp_d[i]) begin
          n_err++;
          $display("FAIL wrap_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]);
        end
      end
    end
    n_vec++;
    if (stab_err != 0 || addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_stable: got unstable=%0d err=%b want 0 0", stab_err, addr_err);
    end
  endtask

  task automatic test_rst_mid();
    logic [39:0] obs;
    bit          seen;
    int          k;
    clear_sb();
    arb_mode = 0; wt_mode = 0; dly = 10; jit = 0;
    issue(32'h4000, 16'd8);
    k = 0;
    while (cmd_q.size() < 3 && k < 20) begin
      step();
      k++;
    end
    arb_mode = 2;
    step();
    n_vec++;
    if (cmd_q.size() != 3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_setup: got cmds=%0d busy=%b want 3 1", cmd_q.size(), busy);
    end
    rst = 1'b1;
    step();
    obs = {busy, done, addr_err, u_if.weight_biu2arb_req, u_if.weight_biu2arb_vld,
           u_if.arb2weight_biu_rdy, wt_vld, wt_last, u_if.weight_biu2arb_addr};
    n_vec++;
    if (obs !== 40'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h want %h", obs, 40'h0);
    end
    rst = 1'b0;
    arb_mode = 0; dly = 2;
    step();
    clear_sb();
    issue(32'h5000, 16'd3);
    wait_done(200, seen);
    step();
    n_vec++;
    if (!seen || cmd_q.size() != 3 || got_d.size() != 3 || addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_restart: got done=%b cmds=%0d words=%0d err=%b want 1 3 3 0",
               seen, cmd_q.size(), got_d.size(), addr_err);
    end else begin
      n_vec++;
      if ({got_d[0], got_d[2], got_l[2]} !== {32'hFFFF_AFFF, 32'hFFFF_AFF7, 1'b1}) begin
        n_err++;
        $display("FAIL rst_restart_data: got %h %h last=%b want ffffafff ffffaff7 1",
                 got_d[0], got_d[2], got_l[2]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_len = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_addr_err();
    test_backpressure();
    test_wrap();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/weight_biu.md
Name: weight_biu

Overview:
- Bus interface unit that fetches a contiguous block of weight words from memory through the ICB master arbiter.
- Upstream of the arbiter on the weight request/response channel; downstream it feeds the weight buffer / PE array with a valid/ready word stream.
- One start command fetches word_len 32-bit words from base_addr with incrementing addresses.
- Multiple reads may be in flight; outstanding reads are credit-limited so response data is never dropped.

Parameters:
- FIFO_DEPTH, 8, response FIFO depth in words (power of 2, >=2); also the cap on outstanding reads plus buffered words.
- LEN_W, 16, width of the word_len command field.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle command strobe; accepted only in IDLE.
- base_addr  in  32  byte address of first word; bits[1:0] ignored (treated as 0).
- word_len  in  LEN_W  number of words to fetch; 0 is legal.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  1-cycle pulse after the last word has left on the stream.
- addr_err  out  1  sticky; set on response address mismatch, cleared by rst or accepted start.
- weight_biu2arb_req  out  1  ownership request; high while read commands remain to be issued.
- weight_biu2arb_addr  out  32  read word address.
- weight_biu2arb_vld  out  1  read command valid.
- weight_biu2arb_rdy  in  1  command accepted when vld&&rdy.
- arb2weight_biu_addr  in  32  address of returned word.
- arb2weight_biu_data  in  32  returned word.
- arb2weight_biu_vld  in  1  response valid.
- arb2weight_biu_rdy  out  1  response ready, = FIFO not full.
- wt_data  out  32  weight word to consumer.
- wt_vld  out  1  = FIFO not empty.
- wt_rdy  in  1  consumer ready.
- wt_last  out  1  high with the final word of the command.

Behaviour:
- Reset values: all outputs 0. State IDLE. Counters 0. FIFO empty.
- FSM states:
  - IDLE: start with word_len>0 latches base_addr&~3, word_len, clears issue/pop counters and addr_err, then goes to RUN. start with word_len==0 goes to DONE.
  - RUN: issue reads. Go to DRAIN in the cycle after the final command handshake.
  - DRAIN: wait until all words are popped.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in RUN and DRAIN.
- Command channel:
  - weight_biu2arb_req=1 in RUN.
  - vld=1 when state==RUN and (outstanding + fifo_count) < FIFO_DEPTH.
  - Once vld is asserted, addr must stay stable until the handshake. vld never drops without a handshake, because credit only shrinks on issue.
  - addr = base + 4*issued_cnt, 32-bit wraparound at 0xFFFF_FFFC -> 0x0000_0000.
- outstanding counter:
  - +1 on command handshake, -1 on response handshake; both in one cycle leaves it unchanged.
  - Width is clog2(FIFO_DEPTH)+1.
- Response channel:
  - Push to FIFO on vld&&rdy.
  - Credit rule guarantees the FIFO never overflows, so rdy is normally 1.
  - Returned words arrive in order. Each response addr is compared with expected = base + 4*rsp_cnt; a mismatch sets addr_err but the data is still pushed.
- Stream: wt_data/wt_vld come from the FIFO head; pop on wt_vld&&wt_rdy.
- wt_last=1 when pop_cnt == word_len-1 and wt_vld.
- When the final word pops, the FSM moves from DRAIN to DONE in the next cycle.
- Simultaneous push and pop on a full or empty FIFO: push and pop both succeed, except that pop is blocked when empty (no write-through bypass; first-word latency is 1 cycle after push).
- Simultaneous events:
  - start while not IDLE is ignored.
  - A response arriving in IDLE is an error: it is dropped (rdy=0 in IDLE) and sets addr_err.
- rst mid-operation:
  - Everything returns to reset values within 1 cycle and the FIFO is flushed.
  - The arbiter side is expected to be reset together with this block.
- Latency: first command vld in the cycle after start; done at least 1 cycle after the wt_last handshake.

Decomposition:
- Shared package acc_biu_pkg holds:
  - WORD_BYTES=4.
  - The BIU state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - A function for clog2 width.
- imap_biu reuses the same package.
- One sub-module: biu_rsp_fifo, a synchronous single-clock FIFO with parameters DEPTH and WIDTH=32.
  - Outputs: full, empty, count.
  - Synchronous active-high reset.

Test Plan:
- base=0x1000, len=4, arb rdy=1, rsp returned 2 cycles after each command, wt_rdy=1 -> addresses 0x1000/04/08/0C, data streamed in order, wt_last on 4th word, single done pulse, addr_err=0.
- len=20, FIFO_DEPTH=8, wt_rdy=0 until cycle 50 -> exactly 8 commands issued, then vld=0; arb2weight_biu_rdy stays 1; after wt_rdy=1 all 20 words delivered, no loss or duplication.
- len=0 start -> busy stays 0, done pulses 2 cycles after start, no command issued.
- Response addr 0x1008 returned where 0x1004 expected -> addr_err=1 sticky, data still streamed; next start clears addr_err.
- Random arb rdy/rsp delays with wt_rdy toggling, base=0xFFFF_FFF8, len=4 -> addresses wrap to 0x0 and 0x4; vld/addr stable while rdy=0.
- rst asserted for 1 cycle mid-RUN with 3 outstanding reads -> all outputs 0 and FIFO empty next cycle; a new start then completes normally.
